imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Write-side counterpart of the instruction-memory read path. Accepts a byte
//   stream over a valid/ready handshake and assembles little-endian 32-bit
//   instructions. Writes them into a DEPTH x 32 register array. Exposes the
//   same combinational 64-bit-address read port the fetch stage uses, so a
//   program can be loaded before or between runs. Holds the core via busy.
// PARAMETERS
//   DEPTH     32      number of 32-bit instruction words (power of 2)
//   OOR_DATA  32'd15  word returned for any read address > DEPTH-1
// PORTS
//   clk        in   1   single clock, all state on rising edge
//   rst_n      in   1   asynchronous, active-low reset
//   start      in   1   begin load of num_words words at word address 0
//   num_words  in   6   words to load; 0 or >DEPTH means DEPTH
//   in_valid   in   1   in_byte holds a valid byte
//   in_byte    in   8   program byte, least significant byte of each word first
//   in_ready   out  1   loader accepts a byte this cycle
//   busy       out  1   load in progress, the core must stall fetch
//   done       out  1   one-cycle pulse after the last word is written
//   rd_addr    in   64  fetch word address
//   rd_data    out  32  instruction at rd_addr (combinational)
// BEHAVIOUR
//   Reset (async, rst_n=0)
//     - state=IDLE; all memory words, the assembly register, wr_ptr, byte_cnt
//       and the count register clear to 0.
//     - in_ready=0, busy=0, done=0.
//     - Reset asserted mid-load discards the partial word. Words already
//       written are also cleared.
//   States IDLE -> LOAD -> DONE -> IDLE
//     IDLE: in_ready=0.
//       - start=1: latch count=clamp(num_words), wr_ptr=0, byte_cnt=0, go LOAD.
//       - A byte offered in the same cycle as start is not accepted.
//     LOAD: in_ready=1, busy=1.
//       - A byte is accepted on an edge where in_valid & in_ready.
//       - Accepted byte goes to assembly lane byte_cnt (lane0=[7:0] ... lane3=[31:24]).
//       - byte_cnt increments and wraps 3->0.
//       - On the 4th accepted byte, the full word (with that byte in [31:24]) is
//         written to mem[wr_ptr] on the same edge, and wr_ptr increments.
//       - If wr_ptr==count-1 at that edge, go DONE.
//       - in_valid=0 stalls with no state change. Stalls are unbounded.
//     DONE: in_ready=0, busy=1, done=1 for exactly one cycle, then IDLE.
//     start while not in IDLE is ignored.
//   Clamp: num_words in 1..DEPTH is used as given; num_words of 0 or >DEPTH loads DEPTH words.
//   Read port (combinational, independent of state)
//     - rd_addr > DEPTH-1 gives rd_data=OOR_DATA.
//     - Otherwise rd_data=mem[rd_addr[log2(DEPTH)-1:0]].
//     - A write is visible on rd_data from the cycle after its write edge.
//     - Reads during LOAD return the partially loaded content.
//   Words at addresses >= count keep their previous contents.
// TESTING
//   1. Reset: rst_n=0 -> in_ready=0, busy=0, done=0, rd_data=0 for addr 0..31.
//      rd_addr=64'd40 -> rd_data=32'd15.
//   2. Load two words: start, num_words=2, bytes 13,00,50,00,93,00,00,00 with
//      in_valid held high -> mem[0]=32'h0050_0013, mem[1]=32'h0000_0093.
//      done pulses on the edge after the 8th byte. mem[2] is unchanged.
//   3. Backpressure: drop in_valid for 5 cycles between bytes 2 and 3 ->
//      same final contents; busy stays 1 throughout; no extra write.
//   4. Clamp: num_words=0, and separately num_words=40 -> exactly 32 words are
//      written (128 bytes); done fires after byte 128; wr_ptr wraps to 0.
//   5. Ignored start: pulse start mid-LOAD with num_words=1 -> original count is
//      kept; a byte offered with start in IDLE is not accepted (in_ready=0).
//   6. Reset mid-load: rst_n low after byte 6 of a 3-word load -> all words 0,
//      state IDLE. A later new load succeeds from word 0.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader into the instruction memory, with the fetch read port
module imem_loader #(
  parameter int          DEPTH    = 32,
  parameter logic [31:0] OOR_DATA = 32'd15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  num_words,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  input  logic [63:0] rd_addr,
  output logic [31:0] rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  // Lanes 0..2 of the word being assembled; lane 3 comes straight from in_byte.
  logic [23:0]   asm_q, asm_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic          use_depth;
  logic          last_word;

  // State, memory and datapath registers; reset wipes everything including loaded words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      asm_q      <= '0;
      wr_ptr_q   <= '0;
      byte_cnt_q <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      asm_q      <= asm_d;
      wr_ptr_q   <= wr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  // Next-state, byte assembly, word write and handshake/status outputs.
  always_comb begin
    state_d    = state_q;
    asm_d      = asm_q;
    wr_ptr_d   = wr_ptr_q;
    byte_cnt_d = byte_cnt_q;
    count_d    = count_q;
    mem_d      = mem_q;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    // A zero or oversized request means "fill the whole memory".
    use_depth  = (num_words == 6'd0) || (int'(num_words) > DEPTH);
    last_word  = ({1'b0, wr_ptr_q} == (count_q - CW'(1)));

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d    = use_depth ? CW'(DEPTH) : CW'(num_words);
          wr_ptr_d   = '0;
          byte_cnt_d = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: asm_d[7:0]   = in_byte;
            2'd1: asm_d[15:8]  = in_byte;
            2'd2: asm_d[23:16] = in_byte;
            default: begin
              mem_d[wr_ptr_q] = {in_byte, asm_q};
              wr_ptr_d        = wr_ptr_q + AW'(1);
              if (last_word) begin
                state_d = S_DONE;
              end
            end
          endcase
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Fetch read port: anything beyond the last word reads the out-of-range constant.
  always_comb begin
    rd_data = mem_q[rd_addr[AW-1:0]];
    if (rd_addr > 64'(DEPTH - 1)) begin
      rd_data = OOR_DATA;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard testbench for imem_loader
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  num_words = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = '0;
  logic [63:0] rd_addr = '0;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic [31:0] rd_data;

  imem_loader #(.DEPTH(DEPTH), .OOR_DATA(32'd15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_words (num_words),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int last_hs = 0;
  int hs_base = 0;
  int req = 0;
  int ack = 0;
  int ld_issued = 0;
  int ld_done_cnt = 0;

  logic [31:0]          ref_mem [DEPTH];
  logic [32*DEPTH-1:0]  ld_img_q [$];
  int                   ld_bytes_q [$];
  int                   rq_kind_q [$];
  logic [2:0]           rq_stat_q [$];
  logic [32*DEPTH-1:0]  rq_img_q [$];
  string                rq_name_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Count accepted bytes and remember the cycle of the latest one.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) hs_cnt <= 0;
    else if (in_valid && in_ready) begin
      hs_cnt  <= hs_cnt + 1;
      last_hs <= cyc;
    end
  end

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic sweep(input string nm, input logic [32*DEPTH-1:0] img);
    logic [63:0] big;
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = 64'(i);
      #1;
      cmp($sformatf("%s_mem%0d", nm, i), 64'(rd_data), 64'(img[i*32 +: 32]));
    end
    rd_addr = 64'd40;
    #1 cmp({nm, "_oor40"}, 64'(rd_data), 64'd15);
    rd_addr = 64'd32;
    #1 cmp({nm, "_oor32"}, 64'(rd_data), 64'd15);
    rd_addr = 64'h8000_0000_0000_0000;
    #1 cmp({nm, "_oor_msb"}, 64'(rd_data), 64'd15);
    big = {32'($urandom), 32'($urandom)} | 64'h100;
    rd_addr = big;
    #1 cmp({nm, "_oor_rand"}, 64'(rd_data), 64'd15);
  endtask

  function automatic logic [32*DEPTH-1:0] pack_ref();
    logic [32*DEPTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i*32 +: 32] = ref_mem[i];
    return v;
  endfunction

  // Monitor: checks every completed load at its done pulse and serves check requests.
  initial begin : monitor
    logic [32*DEPTH-1:0] img;
    logic [2:0]          st;
    string               nm;
    int                  nb;
    int                  k;
    forever begin
      @(negedge clk);
      if (done) begin
        cmp("done_busy", 64'(busy), 64'd1);
        cmp("done_in_ready", 64'(in_ready), 64'd0);
        if (ld_img_q.size() == 0) begin
          cmp("unexpected_done", 64'(done), 64'd0);
        end else begin
          img = ld_img_q.pop_front();
          nb  = ld_bytes_q.pop_front();
          cmp("load_bytes", 64'(hs_cnt - hs_base), 64'(nb));
          hs_base = hs_cnt;
          cmp("done_latency", 64'(cyc - last_hs), 64'd1);
          @(negedge clk);
          cmp("done_pulse_width", 64'(done), 64'd0);
          cmp("idle_after_done", 64'(busy), 64'd0);
          sweep("load", img);
          ld_done_cnt++;
        end
      end else if (req != ack) begin
        k   = rq_kind_q.pop_front();
        st  = rq_stat_q.pop_front();
        img = rq_img_q.pop_front();
        nm  = rq_name_q.pop_front();
        if (k == 0) begin
          cmp(nm, {61'd0, in_ready, busy, done}, {61'd0, st});
        end else begin
          sweep(nm, img);
          hs_base = hs_cnt;
        end
        ack++;
      end
    end
  end

  task automatic wait_ack();
    int t = 0;
    while (ack != req && t < 20000) begin
      #1;
      t++;
    end
    if (ack != req) begin
      $display("FAIL monitor_ack: actual=timeout expected=ack");
      $fatal(1, "monitor stuck");
    end
  endtask

  task automatic req_status(input string nm, input logic [2:0] st);
    rq_kind_q.push_back(0);
    rq_stat_q.push_back(st);
    rq_img_q.push_back('0);
    rq_name_q.push_back(nm);
    req++;
    wait_ack();
  endtask

  task automatic req_mem(input string nm);
    rq_kind_q.push_back(1);
    rq_stat_q.push_back(3'b000);
    rq_img_q.push_back(pack_ref());
    rq_name_q.push_back(nm);
    req++;
    wait_ack();
  endtask

  // One load: stall_at/restart_at/abort_at are byte indices (-1 = never).
  task automatic do_load(input string nm, input int nw, input int stall_at, input int stall_len,
                         input bit offer_with_start, input int restart_at, input int abort_at,
                         input bit fixed);
    logic [7:0] prog [8] = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00};
    logic [7:0] bytes [$];
    int cnt;
    int nb;
    int t;
    cnt = (nw == 0 || nw > DEPTH) ? DEPTH : nw;
    nb  = 4 * cnt;
    for (int i = 0; i < nb; i++) bytes.push_back((fixed && i < 8) ? prog[i] : 8'($urandom));
    if (abort_at < 0) begin
      for (int w = 0; w < cnt; w++)
        ref_mem[w] = {bytes[4*w+3], bytes[4*w+2], bytes[4*w+1], bytes[4*w]};
      ld_img_q.push_back(pack_ref());
      ld_bytes_q.push_back(nb);
      ld_issued++;
    end
    @(posedge clk); #1;
    start = 1'b1;
    num_words = 6'(nw);
    if (offer_with_start) begin
      in_valid = 1'b1;
      in_byte  = 8'($urandom);
    end
    req_status({nm, "_start_cycle"}, 3'b000);
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b0;
    req_status({nm, "_loading"}, 3'b110);
    for (int i = 0; i < nb; i++) begin
      if (i == abort_at) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        for (int w = 0; w < DEPTH; w++) ref_mem[w] = '0;
        req_status({nm, "_in_reset"}, 3'b000);
        req_mem({nm, "_reset_mem"});
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_status({nm, "_idle_after_reset"}, 3'b000);
        return;
      end
      if (i == stall_at) begin
        in_valid = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          req_status({nm, "_stall"}, 3'b110);
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_byte  = bytes[i];
      if (i == restart_at) begin
        start = 1'b1;
        num_words = 6'd1;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b0;
    t = 0;
    while (ld_done_cnt != ld_issued && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (ld_done_cnt != ld_issued) begin
      $display("FAIL %s_done_timeout: actual=%0d expected=%0d", nm, ld_done_cnt, ld_issued);
      $fatal(1, "load never completed");
    end
  endtask

  initial begin : stimulus
    int nw;
    int sa;
    for (int w = 0; w < DEPTH; w++) ref_mem[w] = '0;
    repeat (2) @(posedge clk);
    #1;
    req_status("reset_status", 3'b000);
    req_mem("reset_mem");
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_status("idle_after_reset", 3'b000);

    do_load("two_words",     2,  -1, 0, 1'b0, -1, -1, 1'b1);
    do_load("fill4",         4,  -1, 0, 1'b0, -1, -1, 1'b0);
    do_load("backpressure",  2,   2, 5, 1'b0, -1, -1, 1'b1);
    do_load("clamp0",        0,  -1, 0, 1'b0, -1, -1, 1'b0);
    do_load("clamp40",       40, -1, 0, 1'b0, -1, -1, 1'b0);
    do_load("after_wrap",    3,  -1, 0, 1'b0, -1, -1, 1'b0);
    do_load("ignored_start", 3,  -1, 0, 1'b1,  5, -1, 1'b0);
    do_load("reset_mid",     3,  -1, 0, 1'b0, -1,  6, 1'b0);
    do_load("after_reset",   2,  -1, 0, 1'b0, -1, -1, 1'b0);
    for (int r = 0; r < 6; r++) begin
      nw = $urandom_range(0, 63);
      sa = $urandom_range(0, 40);
      do_load($sformatf("rand%0d", r), nw, sa, $urandom_range(0, 4), 1'($urandom), -1, -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
